// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and
// oversampling constants used by both directions of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  // Tick index of the bit centre counted from the start edge, and the
  // last tick of a full bit period.
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

endpackage

// File: rtl/bit_sync.sv
// Multi-stage synchroniser for a single asynchronous input; the reset
// value is a parameter so idle-high lines come out of reset idle.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= {STAGES{RST_VAL}};
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by the shared 16x oversampling tick.
// Deserialises LSB-first frames and flags a low stop bit as a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 b_16tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  // state is left as a plain internal signal so checkers can bind to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          rx_busy <= 1'b0;
          // Start detection ignores the tick, so a coincident tick is not counted.
          if (!rxs) begin
            state    <= START;
            tick_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end

        START: begin
          if (b_16tick) begin
            if (tick_cnt == MID_TICK) begin
              if (!rxs) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state    <= IDLE;
                tick_cnt <= '0;
                rx_busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (b_16tick) begin
            if (tick_cnt == LAST_TICK) begin
              shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
              tick_cnt  <= '0;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (b_16tick) begin
            if (tick_cnt == LAST_TICK) begin
              rx_data   <= shift_reg;
              rx_done   <= 1'b1;
              frame_err <= ~rxs;
              tick_cnt  <= '0;
              // Returning at the stop-bit centre leaves half a bit to catch
              // a back-to-back start edge.
              if (rxs) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        BREAK: begin
          rx_busy <= 1'b1;
          if (rxs) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial-line driver acts as the transmitter, a
// scoreboard queue holds {frame_err, byte} expected per frame.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       b_16tick;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tick_div = 2;
  int div_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[4];

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .b_16tick  (b_16tick),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  // clock / reset / baud tick
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial b_16tick = 1'b0;
  always @(posedge clk) begin
    if (div_cnt >= tick_div - 1) begin
      div_cnt  <= 0;
      b_16tick <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1;
      b_16tick <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rx_done) begin
      logic [8:0] exp;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got data=%h ferr=%b expected no rx_done at %0t",
                 rx_data, frame_err, $time);
      end else begin
        exp = exp_q.pop_front();
        check("rx_data", {1'b0, rx_data}, {1'b0, exp[7:0]});
        check("frame_err", {8'h00, frame_err}, {8'h00, exp[8]});
        last_data = exp[7:0];
      end
    end
  end

  // driver tasks
  task automatic wait_tick();
    do @(negedge clk); while (b_16tick !== 1'b1);
  endtask

  task automatic hold_line(input logic level, input int ticks);
    rx = level;
    repeat (ticks) wait_tick();
  endtask

  task automatic send_bits(input logic [7:0] data, input int nbits);
    hold_line(1'b0, 16);
    for (int i = 0; i < nbits; i++) hold_line(data[i], 16);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic exp_ferr);
    exp_q.push_back({exp_ferr, data});
    send_bits(data, 8);
    hold_line(stop, 16);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {8'h00, exp_q.size() != 0}, 9'h000);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 4, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 0, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h81, stop: 1'b1, gap: 8, exp_ferr: 1'b0};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", {1'b0, rx_data}, 9'h000);
    check("reset_rx_done", {8'h00, rx_done}, 9'h000);
    check("reset_rx_busy", {8'h00, rx_busy}, 9'h000);
    check("reset_frame_err", {8'h00, frame_err}, 9'h000);
    rst = 1'b0;
    hold_line(1'b1, 20);

    // table: single frame, then back-to-back with no idle gap
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].exp_ferr);
      if (vecs[i].gap > 0) begin
        hold_line(1'b1, vecs[i].gap);
        check("busy_after_frame", {8'h00, rx_busy}, 9'h000);
      end
    end
    drain("table_drain");
    check("done_count_table", done_cnt[8:0], 9'd4);

    // glitch: start edge too short to survive the mid-start sample
    done_cnt = 0;
    hold_line(1'b0, 4);
    hold_line(1'b1, 24);
    check("glitch_busy", {8'h00, rx_busy}, 9'h000);
    check("glitch_data_kept", {1'b0, rx_data}, {1'b0, last_data});
    check("glitch_no_done", done_cnt[8:0], 9'd0);

    // break: low stop bit then line held low
    exp_q.push_back({1'b1, 8'h3C});
    send_bits(8'h3C, 8);
    hold_line(1'b0, 16 + 40);
    check("break_busy", {8'h00, rx_busy}, 9'h001);
    check("break_one_done", done_cnt[8:0], 9'd1);
    hold_line(1'b1, 16);
    check("break_exit_busy", {8'h00, rx_busy}, 9'h000);
    send_frame(8'h11, 1'b1, 1'b0);
    hold_line(1'b1, 4);
    drain("break_drain");
    check("break_done_count", done_cnt[8:0], 9'd2);

    // reset mid-frame discards the partial byte
    done_cnt = 0;
    send_bits(8'hC3, 3);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", {1'b0, rx_data}, 9'h000);
    check("midrst_rx_busy", {8'h00, rx_busy}, 9'h000);
    check("midrst_rx_done", {8'h00, rx_done}, 9'h000);
    check("midrst_frame_err", {8'h00, frame_err}, 9'h000);
    last_data = 8'h00;
    rst = 1'b0;
    hold_line(1'b1, 24);
    check("after_rst_no_done", done_cnt[8:0], 9'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold_line(1'b1, 4);
    drain("rst_drain");
    check("after_rst_data", {1'b0, rx_data}, 9'h05A);

    // loopback-style stream of every byte, back-to-back, tick every clock
    tick_div = 1;
    hold_line(1'b1, 20);
    done_cnt = 0;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1'b0);
    hold_line(1'b1, 8);
    drain("loop_drain");
    check("loop_done_count", done_cnt[8:0], 9'd256);
    check("loop_last_data", {1'b0, rx_data}, 9'h0FF);
    check("loop_busy_idle", {8'h00, rx_busy}, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
